// File: rtl/note_selector.sv
// Note selector: synchronises and debounces 8 note keys plus octave up/down buttons, keeps the
// last-pressed note and drives the tone half-period (in 48 kHz frames) to the I2S transmitter.
module note_selector #(
  parameter int SAMPLE_DIV     = 12288,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_n,
  input  logic       oct_up_n,
  input  logic       oct_dn_n,
  input  logic       mute,
  output logic [7:0] wave_half_period,
  output logic       note_valid,
  output logic [2:0] active_note,
  output logic [1:0] octave,
  output logic       dbg_state
);

  typedef enum logic {IDLE = 1'b0, PLAYING = 1'b1} state_t;

  localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  logic [9:0]      w_raw;
  logic [9:0]      r_sync1, r_sync2;
  logic [PW-1:0]   r_presc;
  logic            w_tick;
  logic [9:0]      r_deb, r_deb_d;
  logic [9:0][2:0] r_cnt;
  logic [9:0]      w_press;
  logic [7:0]      w_note_press, w_note_rel, w_held;
  state_t          r_state, w_state_nx;
  logic [2:0]      r_sel, w_sel_nx;
  logic [1:0]      r_oct;
  logic [7:0]      r_whp;
  logic            r_valid;
  logic [2:0]      r_note;

  function automatic logic [2:0] f_lowest(input logic [7:0] v);
    f_lowest = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (v[i]) f_lowest = 3'(i);
  endfunction

  function automatic logic [7:0] f_base(input logic [2:0] idx);
    case (idx)
      3'd0:    f_base = 8'd91;
      3'd1:    f_base = 8'd81;
      3'd2:    f_base = 8'd72;
      3'd3:    f_base = 8'd68;
      3'd4:    f_base = 8'd60;
      3'd5:    f_base = 8'd54;
      3'd6:    f_base = 8'd48;
      default: f_base = 8'd45;
    endcase
  endfunction

  // Octave scaling works on p = base+1 so halving/doubling tracks the real period.
  function automatic logic [7:0] f_scaled(input logic [7:0] b, input logic [1:0] oct);
    logic [8:0] p;
    logic [9:0] dbl;
    p   = {1'b0, b} + 9'd1;
    dbl = {p, 1'b0} - 10'd1;
    case (oct)
      2'd0:    f_scaled = (dbl > 10'd255) ? 8'hFF : 8'(dbl);
      2'd1:    f_scaled = b;
      2'd2:    f_scaled = 8'((p >> 1) - 9'd1);
      default: f_scaled = 8'((p >> 2) - 9'd1);
    endcase
  endfunction

  assign w_raw = {oct_dn_n, oct_up_n, key_n};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_tick = (r_presc == PW'(SAMPLE_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_presc <= '0;
    else      r_presc <= w_tick ? '0 : r_presc + PW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_deb <= '1;
      r_cnt <= '0;
    end else if (w_tick) begin
      for (int i = 0; i < 10; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == 3'(STABLE_SAMPLES - 1)) begin
          r_deb[i] <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 3'd1;
        end
      end
    end
  end

  // Edge pulses come from comparing against last cycle's debounced level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_deb_d <= '1;
    else      r_deb_d <= r_deb;
  end

  assign w_press      = r_deb_d & ~r_deb;
  assign w_note_press = w_press[7:0];
  assign w_note_rel   = ~r_deb_d[7:0] & r_deb[7:0];
  assign w_held       = ~r_deb[7:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_sel   <= 3'd0;
    end else begin
      r_state <= w_state_nx;
      r_sel   <= w_sel_nx;
    end
  end

  // Release is resolved first so a same-cycle press always overrides it.
  always_comb begin
    w_state_nx = r_state;
    w_sel_nx   = r_sel;
    if (r_state == PLAYING && w_note_rel[r_sel]) begin
      if (|w_held) w_sel_nx = f_lowest(w_held);
      else         w_state_nx = IDLE;
    end
    if (|w_note_press) begin
      w_state_nx = PLAYING;
      w_sel_nx   = f_lowest(w_note_press);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_oct <= 2'd1;
    end else if (w_press[8] && !w_press[9] && r_oct != 2'd3) begin
      r_oct <= r_oct + 2'd1;
    end else if (w_press[9] && !w_press[8] && r_oct != 2'd0) begin
      r_oct <= r_oct - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_whp   <= 8'd0;
      r_valid <= 1'b0;
      r_note  <= 3'd0;
    end else begin
      if (r_state == PLAYING && !mute) begin
        r_whp   <= f_scaled(f_base(r_sel), r_oct);
        r_valid <= 1'b1;
      end else begin
        r_whp   <= 8'd0;
        r_valid <= 1'b0;
      end
      r_note <= (r_state == PLAYING) ? r_sel : 3'd0;
    end
  end

  assign wave_half_period = r_whp;
  assign note_valid       = r_valid;
  assign active_note      = r_note;
  assign octave           = r_oct;
  assign dbg_state        = r_state;

endmodule

// File: tb/tb_note_selector.sv
// Bench for note_selector: directed button sequences; expected output snapshots are queued by the
// stimulus and consumed by a monitor that fires on every change of the DUT outputs.
module tb_note_selector;
  localparam int DIV    = 16;
  localparam int SETTLE = 6 * DIV;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] key_n    = 8'hFF;
  logic       oct_up_n = 1'b1;
  logic       oct_dn_n = 1'b1;
  logic       mute     = 1'b0;
  logic [7:0] wave_half_period;
  logic       note_valid;
  logic [2:0] active_note;
  logic [1:0] octave;
  logic       dbg_state;

  note_selector #(.SAMPLE_DIV(DIV), .STABLE_SAMPLES(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .key_n            (key_n),
    .oct_up_n         (oct_up_n),
    .oct_dn_n         (oct_dn_n),
    .mute             (mute),
    .wave_half_period (wave_half_period),
    .note_valid       (note_valid),
    .active_note      (active_note),
    .octave           (octave),
    .dbg_state        (dbg_state)
  );

  // scoreboard: snapshot = {wave_half_period, note_valid, active_note, octave}
  logic [13:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        mon_en = 1'b0;
  logic [13:0] prev   = 14'd1;
  logic [13:0] cur;
  logic [13:0] e;
  logic        chk_req = 1'b0;
  logic [14:0] chk_exp = '0;
  string       chk_name = "";
  logic        done_req = 1'b0;
  logic        done_ack = 1'b0;

  function automatic logic [13:0] snap(input logic [7:0] w, input logic v,
                                       input logic [2:0] n, input logic [1:0] o);
    return {w, v, n, o};
  endfunction

  always @(negedge clk) begin
    cur = {wave_half_period, note_valid, active_note, octave};
    if (chk_req) begin
      checks++;
      if ({cur, dbg_state} !== chk_exp) begin
        errors++;
        $display("FAIL %s: got whp=%0d valid=%0d note=%0d oct=%0d state=%0d, want whp=%0d valid=%0d note=%0d oct=%0d state=%0d",
                 chk_name, wave_half_period, note_valid, active_note, octave, dbg_state,
                 chk_exp[14:7], chk_exp[6], chk_exp[5:3], chk_exp[2:1], chk_exp[0]);
      end
    end
    if (mon_en && cur !== prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: got whp=%0d valid=%0d note=%0d oct=%0d, want no change",
                 cur[13:6], cur[5], cur[4:2], cur[1:0]);
      end else begin
        e = exp_q.pop_front();
        if (cur !== e) begin
          errors++;
          $display("FAIL output_snapshot: got whp=%0d valid=%0d note=%0d oct=%0d, want whp=%0d valid=%0d note=%0d oct=%0d",
                   cur[13:6], cur[5], cur[4:2], cur[1:0], e[13:6], e[5], e[4:2], e[1:0]);
        end
      end
      prev = cur;
    end
    if (done_req && !done_ack) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL missing_changes: got %0d pending expected snapshots, want 0", exp_q.size());
      end
      done_ack = 1'b1;
    end
  end

  // driver tasks
  task automatic settle();
    repeat (SETTLE) @(posedge clk);
  endtask

  task automatic hit(input logic [7:0] mask);
    @(negedge clk);
    key_n = key_n & ~mask;
    settle();
  endtask

  task automatic lift(input logic [7:0] mask);
    @(negedge clk);
    key_n = key_n | mask;
    settle();
  endtask

  task automatic oct_btn(input logic up, input logic dn);
    @(negedge clk);
    oct_up_n = ~up;
    oct_dn_n = ~dn;
    settle();
    @(negedge clk);
    oct_up_n = 1'b1;
    oct_dn_n = 1'b1;
    settle();
  endtask

  task automatic chk(input logic [13:0] s, input logic st, input string name);
    chk_exp  = {s, st};
    chk_name = name;
    chk_req  = 1'b1;
    @(negedge clk);
    #1 chk_req = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    chk(snap(8'd0, 1'b0, 3'd0, 2'd1), 1'b0, "reset_values");
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    repeat (4) @(posedge clk);

    // debounce: a 3-sample glitch is ignored, a held press is accepted
    @(negedge clk);
    key_n[5] = 1'b0;
    repeat (3 * DIV) @(posedge clk);
    key_n[5] = 1'b1;
    settle();
    exp_q.push_back(snap(8'd54, 1'b1, 3'd5, 2'd1)); hit(8'h20);
    exp_q.push_back(snap(8'd0,  1'b0, 3'd0, 2'd1)); lift(8'h20);

    // last-pressed priority and fallback to held key
    exp_q.push_back(snap(8'd91, 1'b1, 3'd0, 2'd1)); hit(8'h01);
    exp_q.push_back(snap(8'd45, 1'b1, 3'd7, 2'd1)); hit(8'h80);
    exp_q.push_back(snap(8'd91, 1'b1, 3'd0, 2'd1)); lift(8'h80);
    exp_q.push_back(snap(8'd0,  1'b0, 3'd0, 2'd1)); lift(8'h01);
    chk(snap(8'd0, 1'b0, 3'd0, 2'd1), 1'b0, "idle_after_release");
    exp_q.push_back(snap(8'd91, 1'b1, 3'd0, 2'd1)); hit(8'h01);
    exp_q.push_back(snap(8'd68, 1'b1, 3'd3, 2'd1)); hit(8'h08);
    lift(8'h01);
    exp_q.push_back(snap(8'd0,  1'b0, 3'd0, 2'd1)); lift(8'h08);
    exp_q.push_back(snap(8'd72, 1'b1, 3'd2, 2'd1)); hit(8'h14);
    exp_q.push_back(snap(8'd0,  1'b0, 3'd0, 2'd1)); lift(8'h14);

    // octave stepping and saturation while a note is held
    exp_q.push_back(snap(8'd91,  1'b1, 3'd0, 2'd1)); hit(8'h01);
    exp_q.push_back(snap(8'd91,  1'b1, 3'd0, 2'd2));
    exp_q.push_back(snap(8'd45,  1'b1, 3'd0, 2'd2)); oct_btn(1'b1, 1'b0);
    exp_q.push_back(snap(8'd45,  1'b1, 3'd0, 2'd3));
    exp_q.push_back(snap(8'd22,  1'b1, 3'd0, 2'd3)); oct_btn(1'b1, 1'b0);
    oct_btn(1'b1, 1'b0);
    chk(snap(8'd22, 1'b1, 3'd0, 2'd3), 1'b1, "octave_top_saturate");
    exp_q.push_back(snap(8'd22,  1'b1, 3'd0, 2'd2));
    exp_q.push_back(snap(8'd45,  1'b1, 3'd0, 2'd2)); oct_btn(1'b0, 1'b1);
    exp_q.push_back(snap(8'd45,  1'b1, 3'd0, 2'd1));
    exp_q.push_back(snap(8'd91,  1'b1, 3'd0, 2'd1)); oct_btn(1'b0, 1'b1);
    exp_q.push_back(snap(8'd91,  1'b1, 3'd0, 2'd0));
    exp_q.push_back(snap(8'd183, 1'b1, 3'd0, 2'd0)); oct_btn(1'b0, 1'b1);
    oct_btn(1'b0, 1'b1);
    oct_btn(1'b1, 1'b1);
    exp_q.push_back(snap(8'd0,   1'b0, 3'd0, 2'd0)); lift(8'h01);

    // mute while playing key6 at octave 0
    exp_q.push_back(snap(8'd97, 1'b1, 3'd6, 2'd0)); hit(8'h40);
    @(negedge clk);
    mute = 1'b1;
    exp_q.push_back(snap(8'd0, 1'b0, 3'd6, 2'd0));
    @(posedge clk);
    chk(snap(8'd0, 1'b0, 3'd6, 2'd0), 1'b1, "mute_next_cycle");
    repeat (4) @(posedge clk);
    @(negedge clk);
    mute = 1'b0;
    exp_q.push_back(snap(8'd97, 1'b1, 3'd6, 2'd0));
    repeat (4) @(posedge clk);

    // asynchronous reset mid-note, key6 still held afterwards
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.push_back(snap(8'd0, 1'b0, 3'd0, 2'd1));
    chk(snap(8'd0, 1'b0, 3'd0, 2'd1), 1'b0, "reset_mid_note");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2 * DIV) @(posedge clk);
    chk(snap(8'd0, 1'b0, 3'd0, 2'd1), 1'b0, "quiet_after_reset");
    exp_q.push_back(snap(8'd48, 1'b1, 3'd6, 2'd1));
    settle();
    exp_q.push_back(snap(8'd0, 1'b0, 3'd0, 2'd1)); lift(8'h40);

    // final report
    done_req = 1'b1;
    for (int i = 0; i < 10 && !done_ack; i++) @(negedge clk);
    if (!done_ack) begin
      errors++;
      $display("FAIL final_check: got no monitor response, want one");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
